// File: rtl/approx_metrics_pkg.sv
// rtl/approx_metrics_pkg.sv - FSM encoding and width helpers shared by the error-metrics monitor
package approx_metrics_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mon_state_e;

    localparam int DEF_N     = 16;
    localparam int DEF_CNT_W = 24;

    // Sum of up to 2^cnt_w-1 values each below 2^n never exceeds n+cnt_w bits.
    function automatic int sum_ed_width(input int n, input int cnt_w);
        return n + cnt_w;
    endfunction

    function automatic int sum_sq_width(input int n, input int cnt_w);
        return 2 * n + cnt_w;
    endfunction

endpackage

// File: rtl/approx_error_monitor_if.sv
// rtl/approx_error_monitor_if.sv - exact/approximate sum sample stream into the monitor
interface approx_error_monitor_if #(
    parameter int N = 16
);
    logic         s_valid;
    logic         s_ready;
    logic [N-1:0] exact_s;
    logic [N-1:0] approx_s;

    modport master (
        output s_valid,
        output exact_s,
        output approx_s,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  exact_s,
        input  approx_s,
        output s_ready
    );
endinterface

// File: rtl/error_distance_stage.sv
// rtl/error_distance_stage.sv - registered error distance, error flag and zero flag per sample
module error_distance_stage #(
    parameter int N       = 16,
    parameter int WRAP_ED = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [N-1:0] exact_s,
    input  logic [N-1:0] approx_s,
    output logic         out_valid,
    output logic [N-1:0] ed,
    output logic         err,
    output logic         zero
);

    logic         v_q, v_d;
    logic [N-1:0] ed_q, ed_d;
    logic         err_q, err_d;
    logic         zero_q, zero_d;

    logic [N:0]   diff;
    logic [N-1:0] dmod;
    logic [N-1:0] dneg;

    always_comb begin
        diff   = {1'b0, approx_s} - {1'b0, exact_s};
        dmod   = diff[N-1:0];
        dneg   = -dmod;
        v_d    = in_valid;
        ed_d   = ed_q;
        err_d  = err_q;
        zero_d = zero_q;
        if (in_valid) begin
            // dneg is 2^N-dmod, which is also |d| when the true difference is negative.
            if (WRAP_ED != 0) begin
                ed_d = (dmod > dneg) ? dneg : dmod;
            end else begin
                ed_d = diff[N] ? dneg : dmod;
            end
            err_d  = (approx_s != exact_s);
            zero_d = (exact_s == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= 1'b0;
            ed_q   <= '0;
            err_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            ed_q   <= ed_d;
            err_q  <= err_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = v_q;
    assign ed        = ed_q;
    assign err       = err_q;
    assign zero      = zero_q;

endmodule

// File: rtl/approx_error_monitor.sv
// rtl/approx_error_monitor.sv - streaming ER/MED/NMED/MSE accumulator for approximate adders
module approx_error_monitor
    import approx_metrics_pkg::*;
#(
    parameter int N       = 16,
    parameter int CNT_W   = 24,
    parameter int SQ_EN   = 1,
    parameter int WRAP_ED = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [CNT_W-1:0]                    num_samples,
    approx_error_monitor_if.slave               smp,
    output logic                                busy,
    output logic                                done,
    output logic [CNT_W-1:0]                    err_count,
    output logic [sum_ed_width(N, CNT_W)-1:0]   sum_ed,
    output logic [N-1:0]                        max_ed,
    output logic [sum_sq_width(N, CNT_W)-1:0]   sum_sq_ed,
    output logic [CNT_W-1:0]                    zero_count
);

    localparam int ED_W = sum_ed_width(N, CNT_W);
    localparam int SQ_W = sum_sq_width(N, CNT_W);

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;
    logic             clear;
    logic             accept;

    logic             v1;
    logic [N-1:0]     ed1;
    logic             err1;
    logic             zero1;

    logic             v2_q, v2_d;
    logic [N-1:0]     ed2_q, ed2_d;
    logic [2*N-1:0]   sq2_q, sq2_d;
    logic             err2_q, err2_d;
    logic             zero2_q, zero2_d;

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [ED_W-1:0]  sum_ed_q, sum_ed_d;
    logic [SQ_W-1:0]  sum_sq_q, sum_sq_d;
    logic [N-1:0]     max_ed_q, max_ed_d;

    assign accept = smp.s_valid && (state_q == ST_RUN);

    error_distance_stage #(
        .N       (N),
        .WRAP_ED (WRAP_ED)
    ) u_ed_stage (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (accept),
        .exact_s   (smp.exact_s),
        .approx_s  (smp.approx_s),
        .out_valid (v1),
        .ed        (ed1),
        .err       (err1),
        .zero      (zero1)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        clear   = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    clear   = 1'b1;
                    rem_d   = num_samples;
                    state_d = (num_samples == '0) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Results are final once neither pipe stage holds a sample.
                if (!v1 && !v2_q) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        v2_d    = v1;
        ed2_d   = ed1;
        err2_d  = err1;
        zero2_d = zero1;
        if (SQ_EN != 0) begin
            sq2_d = {{N{1'b0}}, ed1} * {{N{1'b0}}, ed1};
        end else begin
            sq2_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            ed2_q   <= '0;
            sq2_q   <= '0;
            err2_q  <= 1'b0;
            zero2_q <= 1'b0;
        end else begin
            v2_q    <= v2_d;
            ed2_q   <= ed2_d;
            sq2_q   <= sq2_d;
            err2_q  <= err2_d;
            zero2_q <= zero2_d;
        end
    end

    always_comb begin
        err_cnt_d  = err_cnt_q;
        zero_cnt_d = zero_cnt_q;
        sum_ed_d   = sum_ed_q;
        sum_sq_d   = sum_sq_q;
        max_ed_d   = max_ed_q;
        if (clear) begin
            err_cnt_d  = '0;
            zero_cnt_d = '0;
            sum_ed_d   = '0;
            sum_sq_d   = '0;
            max_ed_d   = '0;
        end else if (v2_q) begin
            err_cnt_d  = err_cnt_q + {{(CNT_W-1){1'b0}}, err2_q};
            zero_cnt_d = zero_cnt_q + {{(CNT_W-1){1'b0}}, zero2_q};
            sum_ed_d   = sum_ed_q + {{CNT_W{1'b0}}, ed2_q};
            sum_sq_d   = sum_sq_q + {{CNT_W{1'b0}}, sq2_q};
            if (ed2_q > max_ed_q) begin
                max_ed_d = ed2_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q  <= '0;
            zero_cnt_q <= '0;
            sum_ed_q   <= '0;
            sum_sq_q   <= '0;
            max_ed_q   <= '0;
        end else begin
            err_cnt_q  <= err_cnt_d;
            zero_cnt_q <= zero_cnt_d;
            sum_ed_q   <= sum_ed_d;
            sum_sq_q   <= sum_sq_d;
            max_ed_q   <= max_ed_d;
        end
    end

    assign smp.s_ready = (state_q == ST_RUN);
    assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done        = done_q;
    assign err_count   = err_cnt_q;
    assign zero_count  = zero_cnt_q;
    assign sum_ed      = sum_ed_q;
    assign sum_sq_ed   = sum_sq_q;
    assign max_ed      = max_ed_q;

endmodule

// File: tb/tb_approx_error_monitor.sv
// tb/tb_approx_error_monitor.sv - self-checking bench for the approximate-adder error monitor
module tb_approx_error_monitor;

    localparam int N     = 16;
    localparam int CNT_W = 24;
    localparam int MAXC  = 4000;
    localparam longint MODV = 64'd1 << N;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [CNT_W-1:0] num_samples = '0;
    logic             tb_valid = 1'b0;
    logic [N-1:0]     tb_exact = '0;
    logic [N-1:0]     tb_approx = '0;

    logic             busy_m, done_m, busy_w, done_w;
    logic [CNT_W-1:0] err_m, zc_m, err_w, zc_w;
    logic [N+CNT_W-1:0]   sed_m, sed_w;
    logic [N-1:0]         max_m, max_w;
    logic [2*N+CNT_W-1:0] sq_m, sq_w;

    int n_checks = 0;
    int n_err    = 0;

    logic [N-1:0] qe[$];
    logic [N-1:0] qa[$];

    always #5 clk = ~clk;

    approx_error_monitor_if #(.N(N)) sif_m ();
    approx_error_monitor_if #(.N(N)) sif_w ();

    assign sif_m.s_valid  = tb_valid;
    assign sif_m.exact_s  = tb_exact;
    assign sif_m.approx_s = tb_approx;
    assign sif_w.s_valid  = tb_valid;
    assign sif_w.exact_s  = tb_exact;
    assign sif_w.approx_s = tb_approx;

    approx_error_monitor #(.N(N), .CNT_W(CNT_W), .SQ_EN(1), .WRAP_ED(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .smp(sif_m),
        .busy(busy_m), .done(done_m), .err_count(err_m), .sum_ed(sed_m), .max_ed(max_m),
        .sum_sq_ed(sq_m), .zero_count(zc_m)
    );

    approx_error_monitor #(.N(N), .CNT_W(CNT_W), .SQ_EN(1), .WRAP_ED(1)) u_dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples), .smp(sif_w),
        .busy(busy_w), .done(done_w), .err_count(err_w), .sum_ed(sed_w), .max_ed(max_w),
        .sum_sq_ed(sq_w), .zero_count(zc_w)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Lower-part OR adder with error reduction: K=8 low bits ORed, carry from both low MSBs.
    function automatic logic [15:0] herloa(input logic [15:0] a, input logic [15:0] b);
        logic [7:0] lo;
        logic [8:0] hi;
        logic       cin;
        cin = a[7] & b[7];
        lo  = a[7:0] | b[7:0];
        if (cin) lo[6:0] = 7'h7F;
        hi  = {1'b0, a[15:8]} + {1'b0, b[15:8]} + {8'b0, cin};
        return {hi[7:0], lo};
    endfunction

    // mode 0: back-to-back, 1: valid every other cycle with stray start pulses, 2: random valid
    task automatic do_run(input string nm, input int mode);
        int idx, neg, last_neg, exp_neg;
        bit seen, want, saw_ready, rdy_diff;
        idx = 0; seen = 0; last_neg = -1; saw_ready = 0; rdy_diff = 0;
        @(negedge clk);
        num_samples = CNT_W'(qe.size());
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({nm, "/busy_after_start"}, longint'(busy_m), 1);
        for (neg = 0; neg < MAXC; neg++) begin
            if (neg > 0) @(negedge clk);
            start = 1'b0;
            if (done_m) begin
                seen = 1;
                break;
            end
            if (sif_m.s_ready) saw_ready = 1;
            if (sif_m.s_ready != sif_w.s_ready) rdy_diff = 1;
            want = (idx < qe.size()) &&
                   (mode == 0 || (mode == 1 && (neg % 2) == 0) ||
                    (mode == 2 && $urandom_range(1, 0) == 1));
            tb_valid = want;
            if (want) begin
                tb_exact  = qe[idx];
                tb_approx = qa[idx];
            end
            if (mode == 1 && !want && sif_m.s_ready) start = 1'b1;
            if (want && sif_m.s_ready) begin
                idx++;
                last_neg = neg;
            end
        end
        tb_valid = 1'b0;
        start    = 1'b0;
        chk({nm, "/done_seen"}, longint'(seen), 1);
        exp_neg = (qe.size() == 0) ? 1 : last_neg + 4;
        if (seen) chk({nm, "/done_latency"}, longint'(neg), longint'(exp_neg));
        chk({nm, "/ready_match"}, longint'(rdy_diff), 0);
        if (qe.size() == 0) chk({nm, "/no_ready"}, longint'(saw_ready), 0);
    endtask

    task automatic check_model(input string nm);
        longint ne, se, mx, sq, nz, wse, wmx, wsq, d, ed, dm, wed;
        ne = 0; se = 0; mx = 0; sq = 0; nz = 0; wse = 0; wmx = 0; wsq = 0;
        for (int i = 0; i < qe.size(); i++) begin
            d   = longint'(qa[i]) - longint'(qe[i]);
            ed  = (d < 0) ? -d : d;
            dm  = (d + MODV) % MODV;
            wed = (dm < MODV - dm) ? dm : MODV - dm;
            if (qa[i] != qe[i]) ne++;
            if (qe[i] == 0) nz++;
            se += ed;  sq += ed * ed;   if (ed > mx) mx = ed;
            wse += wed; wsq += wed * wed; if (wed > wmx) wmx = wed;
        end
        chk({nm, "/err_count"},  longint'(err_m), ne);
        chk({nm, "/sum_ed"},     longint'(sed_m), se);
        chk({nm, "/max_ed"},     longint'(max_m), mx);
        chk({nm, "/sum_sq_ed"},  longint'(sq_m),  sq);
        chk({nm, "/zero_count"}, longint'(zc_m),  nz);
        chk({nm, "/w_err"},      longint'(err_w), ne);
        chk({nm, "/w_sum_ed"},   longint'(sed_w), wse);
        chk({nm, "/w_max_ed"},   longint'(max_w), wmx);
        chk({nm, "/w_sum_sq"},   longint'(sq_w),  wsq);
    endtask

    task automatic post_done(input string nm);
        longint held;
        held = longint'(sed_m);
        @(negedge clk);
        chk({nm, "/done_pulse"}, longint'(done_m), 0);
        chk({nm, "/busy_idle"},  longint'(busy_m), 0);
        chk({nm, "/held"},       longint'(sed_m),  held);
    endtask

    typedef struct {
        logic [15:0] ex;
        logic [15:0] ap;
        longint      ed;
        longint      wed;
        bit          err;
        bit          zero;
    } vec_t;

    vec_t vt[10];

    initial begin
        vt[0] = '{16'h1234, 16'h1234,     0,     0, 1'b0, 1'b0};
        vt[1] = '{16'h0100, 16'h00FF,     1,     1, 1'b1, 1'b0};
        vt[2] = '{16'h0000, 16'h0008,     8,     8, 1'b1, 1'b1};
        vt[3] = '{16'hFFFF, 16'hFF00,   255,   255, 1'b1, 1'b0};
        vt[4] = '{16'h0000, 16'hFFFF, 65535,     1, 1'b1, 1'b1};
        vt[5] = '{16'hFFFF, 16'h0000, 65535,     1, 1'b1, 1'b0};
        vt[6] = '{16'h0000, 16'h8000, 32768, 32768, 1'b1, 1'b1};
        vt[7] = '{16'h8001, 16'h0000, 32769, 32767, 1'b1, 1'b0};
        vt[8] = '{16'h0010, 16'h0020,    16,    16, 1'b1, 1'b0};
        vt[9] = '{16'h0000, 16'h0000,     0,     0, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset/busy",    longint'(busy_m), 0);
        chk("reset/done",    longint'(done_m), 0);
        chk("reset/s_ready", longint'(sif_m.s_ready), 0);
        chk("reset/sum_ed",  longint'(sed_m), 0);
        chk("reset/err",     longint'(err_m), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            qe.delete(); qa.delete();
            qe.push_back(vt[i].ex); qa.push_back(vt[i].ap);
            do_run($sformatf("vec%0d", i), 0);
            chk($sformatf("vec%0d/sum_ed", i),   longint'(sed_m), vt[i].ed);
            chk($sformatf("vec%0d/max_ed", i),   longint'(max_m), vt[i].ed);
            chk($sformatf("vec%0d/sum_sq", i),   longint'(sq_m),  vt[i].ed * vt[i].ed);
            chk($sformatf("vec%0d/err", i),      longint'(err_m), longint'(vt[i].err));
            chk($sformatf("vec%0d/zero", i),     longint'(zc_m),  longint'(vt[i].zero));
            chk($sformatf("vec%0d/w_sum_ed", i), longint'(sed_w), vt[i].wed);
        end

        qe.delete(); qa.delete();
        for (int i = 0; i < 4; i++) begin qe.push_back(16'h1234); qa.push_back(16'h1234); end
        do_run("t1_exact", 0);
        chk("t1/err", longint'(err_m), 0);
        chk("t1/sum_ed", longint'(sed_m), 0);
        chk("t1/max_ed", longint'(max_m), 0);
        post_done("t1");

        qe = '{16'h0100, 16'h0000, 16'hFFFF};
        qa = '{16'h00FF, 16'h0008, 16'hFF00};
        do_run("t2_mixed", 0);
        chk("t2/err", longint'(err_m), 3);
        chk("t2/sum_ed", longint'(sed_m), 264);
        chk("t2/max_ed", longint'(max_m), 255);
        chk("t2/sum_sq", longint'(sq_m), 65090);
        chk("t2/zero", longint'(zc_m), 1);
        post_done("t2");

        qe.delete(); qa.delete();
        do_run("t4_empty", 0);
        chk("t4/sum_ed", longint'(sed_m), 0);
        chk("t4/err",    longint'(err_m), 0);
        chk("t4/sum_sq", longint'(sq_m),  0);
        chk("t4/zero",   longint'(zc_m),  0);

        qe.delete(); qa.delete();
        for (int i = 0; i < 5; i++) begin qe.push_back(16'h0100); qa.push_back(16'h0102); end
        do_run("t5_gaps", 1);
        chk("t5/sum_ed", longint'(sed_m), 10);
        chk("t5/err",    longint'(err_m), 5);
        post_done("t5");

        begin
            int dones;
            @(negedge clk);
            num_samples = 24'd10;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tb_valid = 1'b1; tb_exact = 16'h0000; tb_approx = 16'h0005;
                @(negedge clk);
            end
            tb_valid = 1'b0;
            repeat (2) @(negedge clk);
            chk("t6/mid_sum_ed", longint'(sed_m), 15);
            rst_n = 1'b0;
            #1;
            chk("t6/rst_sum_ed",  longint'(sed_m), 0);
            chk("t6/rst_err",     longint'(err_m), 0);
            chk("t6/rst_zero",    longint'(zc_m),  0);
            chk("t6/rst_max",     longint'(max_m), 0);
            chk("t6/rst_busy",    longint'(busy_m), 0);
            chk("t6/rst_s_ready", longint'(sif_m.s_ready), 0);
            @(negedge clk);
            rst_n = 1'b1;
            dones = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (done_m || busy_m) dones++;
            end
            chk("t6/no_done_after_abort", longint'(dones), 0);
            qe.delete(); qa.delete();
            for (int i = 0; i < 6; i++) begin qe.push_back(16'h0007); qa.push_back(16'h0003); end
            do_run("t6_restart", 0);
            check_model("t6_restart");
        end

        for (int r = 0; r < 4; r++) begin
            logic [15:0] a, b;
            qe.delete(); qa.delete();
            for (int i = 0; i < 400; i++) begin
                a = 16'($urandom);
                b = 16'($urandom);
                if ($urandom_range(3, 0) != 0) begin
                    qe.push_back(a + b);
                    qa.push_back(herloa(a, b));
                end else begin
                    qe.push_back(a);
                    qa.push_back(b);
                end
            end
            do_run($sformatf("rand%0d", r), (r % 2 == 0) ? 0 : 2);
            check_model($sformatf("rand%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1);
    end

endmodule
